// File: rtl/rv32i_alu_issue.sv
// rv32i_alu_issue: decode-and-issue stage in front of rv32i_alu.
// Decodes an RV32I instruction plus register-read data into a one-hot ALU
// operation and two operands, and issues it through a registered output
// stage backed by one skid entry (2 entries total, one cycle of latency).
// Optional feature macro: RV32I_ALU_ISSUE_ILLEGAL_EN adds the illegal_o port
// and the funct7 legality checks.
module rv32i_alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [9:0]      operation_o,
    output logic [XLEN-1:0] operand1_o,
    output logic [XLEN-1:0] operand2_o,
    output logic [4:0]      rd_o,
    output logic            rd_write_o,
    output logic            branch_o,
    output logic [2:0]      branch_funct3_o
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
    ,
    output logic            illegal_o
`endif
);

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    localparam logic [9:0] ALU_NOP  = 10'h000;
    localparam logic [9:0] ALU_ADD  = 10'h001;
    localparam logic [9:0] ALU_SUB  = 10'h002;
    localparam logic [9:0] ALU_SLT  = 10'h004;
    localparam logic [9:0] ALU_SLTU = 10'h008;
    localparam logic [9:0] ALU_AND  = 10'h010;
    localparam logic [9:0] ALU_OR   = 10'h020;
    localparam logic [9:0] ALU_XOR  = 10'h040;
    localparam logic [9:0] ALU_SLL  = 10'h080;
    localparam logic [9:0] ALU_SRL  = 10'h100;
    localparam logic [9:0] ALU_SRA  = 10'h200;

    // One decoded issue entry; the raw instruction word is never stored.
    typedef struct packed {
        logic [9:0]      operation;
        logic [XLEN-1:0] operand1;
        logic [XLEN-1:0] operand2;
        logic [4:0]      rd;
        logic            rd_write;
        logic            branch;
        logic [2:0]      funct3;
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
        logic            illegal;
`endif
    } entry_t;

    // Shared funct3 -> ALU op table; alt selects SUB/SRA.
    function automatic logic [9:0] f3_to_op(input logic [2:0] f3, input logic alt);
        logic [9:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic            is_shift_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_u_s;
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
    logic [6:0]      funct7_s;
    assign funct7_s = instr_i[31:25];
`endif

    assign opcode_s   = instr_i[6:0];
    assign funct3_s   = instr_i[14:12];
    assign is_shift_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);
    assign imm_i_s    = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_u_s    = {instr_i[31:12], 12'h000};

    entry_t dec_d;

    // Combinational decode of the incoming instruction into an issue entry.
    always_comb begin
        dec_d        = '0;
        dec_d.rd     = instr_i[11:7];
        dec_d.funct3 = funct3_s;
        case (opcode_s)
            OPC_OP: begin
                dec_d.operation = f3_to_op(funct3_s, instr_i[30]);
                dec_d.operand1  = rs1_data_i;
                dec_d.operand2  = rs2_data_i;
                dec_d.rd_write  = 1'b1;
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
                dec_d.illegal   = (funct7_s != 7'h00) && (funct7_s != 7'h20);
`endif
            end
            OPC_OP_IMM: begin
                // Only SRAI has an alternate form; ADDI ignores instr[30].
                dec_d.operation = f3_to_op(funct3_s, instr_i[30] & (funct3_s == 3'b101));
                dec_d.operand1  = rs1_data_i;
                dec_d.operand2  = is_shift_s ? {27'h0000000, instr_i[24:20]} : imm_i_s;
                dec_d.rd_write  = 1'b1;
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
                if (funct3_s == 3'b001) begin
                    dec_d.illegal = (funct7_s != 7'h00);
                end else if (funct3_s == 3'b101) begin
                    dec_d.illegal = (funct7_s != 7'h00) && (funct7_s != 7'h20);
                end else begin
                    dec_d.illegal = 1'b0;
                end
`endif
            end
            OPC_LUI: begin
                dec_d.operation = ALU_ADD;
                dec_d.operand2  = imm_u_s;
                dec_d.rd_write  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.operation = ALU_ADD;
                dec_d.operand1  = pc_i;
                dec_d.operand2  = imm_u_s;
                dec_d.rd_write  = 1'b1;
            end
            OPC_BRANCH: begin
                dec_d.operation = ALU_SUB;
                dec_d.operand1  = rs1_data_i;
                dec_d.operand2  = rs2_data_i;
                dec_d.branch    = 1'b1;
            end
            default: begin
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
                dec_d.illegal = 1'b1;
`endif
            end
        endcase
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
        // Illegal entries still flow through but must not execute or write.
        dec_d.operation = dec_d.illegal ? ALU_NOP : dec_d.operation;
        dec_d.rd_write  = dec_d.illegal ? 1'b0 : dec_d.rd_write;
`endif
        // x0 is never written.
        dec_d.rd_write = dec_d.rd_write & (dec_d.rd != 5'd0);
    end

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept_s;
    logic   consume_s;

    assign accept_s  = in_valid_i & in_ready_q;
    assign consume_s = out_valid_q & out_ready_i;

    // Next-state for the output register and skid entry (FIFO order).
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            // Skid full: input is blocked; skid moves up once output drains.
            if (consume_s) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d  = out_valid_q;
            end
        end else if (!out_valid_q || consume_s) begin
            // Output free this cycle: new entry goes straight to the output.
            if (accept_s) begin
                out_d       = dec_d;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            // Output stalled: park one extra entry in the skid.
            if (accept_s) begin
                skid_d       = dec_d;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    // State registers; reset empties both entries without waiting for a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o      = in_ready_q;
    assign out_valid_o     = out_valid_q;
    assign operation_o     = out_q.operation;
    assign operand1_o      = out_q.operand1;
    assign operand2_o      = out_q.operand2;
    assign rd_o            = out_q.rd;
    assign rd_write_o      = out_q.rd_write;
    assign branch_o        = out_q.branch;
    assign branch_funct3_o = out_q.funct3;
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
    assign illegal_o       = out_q.illegal;
`endif

endmodule

// File: tb/tb_rv32i_alu_issue.sv
// Self-checking bench for rv32i_alu_issue: directed test-plan steps followed
// by random traffic, checked against a queue-based reference model.
module tb_rv32i_alu_issue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [9:0]  operation_o;
    logic [31:0] operand1_o;
    logic [31:0] operand2_o;
    logic [4:0]  rd_o;
    logic        rd_write_o;
    logic        branch_o;
    logic [2:0]  branch_funct3_o;
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
    logic        illegal_o;
`endif

    rv32i_alu_issue #(.XLEN(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .instr_i         (instr_i),
        .pc_i            (pc_i),
        .rs1_data_i      (rs1_data_i),
        .rs2_data_i      (rs2_data_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .operation_o     (operation_o),
        .operand1_o      (operand1_o),
        .operand2_o      (operand2_o),
        .rd_o            (rd_o),
        .rd_write_o      (rd_write_o),
        .branch_o        (branch_o),
        .branch_funct3_o (branch_funct3_o)
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
        ,
        .illegal_o       (illegal_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [9:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wr;
        logic        br;
        logic [2:0]  f3;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t       e;
        logic [9:0] tbl [8];
        logic [2:0] f3;
        logic [6:0] f7;
        tbl = '{10'h001, 10'h080, 10'h004, 10'h008, 10'h040, 10'h100, 10'h020, 10'h010};
        e = '{op: 10'h000, a: 32'h0, b: 32'h0, rd: ins[11:7], wr: 1'b0, br: 1'b0,
              f3: ins[14:12], ill: 1'b0};
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'h33: begin
                e.op = tbl[f3];
                if (ins[30] && f3 == 3'd0) e.op = 10'h002;
                if (ins[30] && f3 == 3'd5) e.op = 10'h200;
                e.a = r1; e.b = r2; e.wr = 1'b1;
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
                e.ill = !(f7 == 7'h00 || f7 == 7'h20);
`endif
            end
            7'h13: begin
                e.op = tbl[f3];
                if (ins[30] && f3 == 3'd5) e.op = 10'h200;
                e.a = r1;
                if (f3 == 3'd1 || f3 == 3'd5) e.b = 32'(ins[24:20]);
                else e.b = 32'($signed(ins[31:20]));
                e.wr = 1'b1;
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
                if (f3 == 3'd1) e.ill = (f7 != 7'h00);
                if (f3 == 3'd5) e.ill = !(f7 == 7'h00 || f7 == 7'h20);
`endif
            end
            7'h37: begin e.op = 10'h001; e.b = {ins[31:12], 12'h000}; e.wr = 1'b1; end
            7'h17: begin e.op = 10'h001; e.a = pc; e.b = {ins[31:12], 12'h000}; e.wr = 1'b1; end
            7'h63: begin e.op = 10'h002; e.a = r1; e.b = r2; e.br = 1'b1; end
            default: begin
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
                e.ill = 1'b1;
`endif
            end
        endcase
        if (e.ill) begin e.op = 10'h000; e.wr = 1'b0; end
        if (e.rd == 5'd0) e.wr = 1'b0;
        if (f7 == 7'h7f && f3 == 3'd7 && 1'b0) e.wr = 1'b0;
        return e;
    endfunction

    task automatic check_outputs();
        exp_t e;
        chk("out_valid", 32'(out_valid_o), 32'(q.size() > 0));
        chk("in_ready",  32'(in_ready_o),  32'(q.size() < 2));
        if (q.size() > 0) begin
            e = q[0];
            chk("operation", 32'(operation_o), 32'(e.op));
            chk("operand1",  operand1_o, e.a);
            chk("operand2",  operand2_o, e.b);
            chk("rd_write",  32'(rd_write_o), 32'(e.wr));
            chk("branch",    32'(branch_o), 32'(e.br));
            if (e.wr) chk("rd", 32'(rd_o), 32'(e.rd));
            if (e.br) chk("funct3", 32'(branch_funct3_o), 32'(e.f3));
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
            chk("illegal", 32'(illegal_o), 32'(e.ill));
`endif
        end
    endtask

    // One clock: model transfers use the inputs held across the edge.
    task automatic cycle();
        bit   acc;
        bit   con;
        exp_t e;
        acc = in_valid_i && (q.size() < 2);
        con = (q.size() > 0) && out_ready_i;
        if (acc) e = model(instr_i, pc_i, rs1_data_i, rs2_data_i);
        @(posedge clk_i);
        #1;
        if (con) void'(q.pop_front());
        if (acc) q.push_back(e);
        check_outputs();
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        in_valid_i = 1'b1;
        instr_i    = ins;
        pc_i       = 32'h0000_1000;
        rs1_data_i = r1;
        rs2_data_i = r2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  opc [6];
        opc = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h00};
        ins = $urandom;
        ins[6:0] = opc[$urandom_range(0, 5)];
        if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
        // Mostly legal funct7 so SUB/SRA/SRAI are exercised often.
        if ($urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return ins;
    endfunction

    logic [31:0] hold_op1;

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        instr_i     = 32'h0;
        pc_i        = 32'h0;
        rs1_data_i  = 32'h0;
        rs2_data_i  = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        // Reset state.
        chk("rst_out_valid", 32'(out_valid_o), 32'h0);
        chk("rst_in_ready",  32'(in_ready_o),  32'h1);
        chk("rst_operation", 32'(operation_o), 32'h0);
        chk("rst_operand1",  operand1_o, 32'h0);
        chk("rst_operand2",  operand2_o, 32'h0);
        chk("rst_rd_write",  32'(rd_write_o), 32'h0);
        chk("rst_branch",    32'(branch_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // ADDI x1,x0,5 appears one cycle after accept.
        drive(32'h0050_0093, 32'd0, 32'd77);
        cycle();
        chk("addi_op",  32'(operation_o), 32'h001);
        chk("addi_op1", operand1_o, 32'd0);
        chk("addi_op2", operand2_o, 32'd5);
        chk("addi_rd",  32'(rd_o), 32'd1);
        chk("addi_wr",  32'(rd_write_o), 32'd1);
        // SUB x3,x1,x2.
        drive(32'h4020_81B3, 32'd10, 32'd3);
        cycle();
        chk("sub_op",  32'(operation_o), 32'h002);
        chk("sub_op1", operand1_o, 32'd10);
        chk("sub_op2", operand2_o, 32'd3);
        // SRAI x5,x6,3.
        drive(32'h4033_5293, 32'hF000_0000, 32'd9);
        cycle();
        chk("srai_op",  32'(operation_o), 32'h200);
        chk("srai_op2", operand2_o, 32'd3);
        // LUI x7,0x12345.
        drive(32'h1234_53B7, 32'h5555_5555, 32'd9);
        cycle();
        chk("lui_op",  32'(operation_o), 32'h001);
        chk("lui_op1", operand1_o, 32'd0);
        chk("lui_op2", operand2_o, 32'h1234_5000);
        // ADD with rd = x0 must not write.
        drive(32'h0020_8033, 32'd1, 32'd2);
        cycle();
        chk("x0_wr", 32'(rd_write_o), 32'd0);
`ifdef RV32I_ALU_ISSUE_ILLEGAL_EN
        drive(32'h0000_0000, 32'd1, 32'd2);
        cycle();
        chk("ill_zero", 32'(illegal_o), 32'd1);
        chk("ill_zero_op", 32'(operation_o), 32'd0);
        chk("ill_zero_wr", 32'(rd_write_o), 32'd0);
        drive(32'h0220_81B3, 32'd1, 32'd2);
        cycle();
        chk("ill_f7", 32'(illegal_o), 32'd1);
`endif

        // Backpressure: three back-to-back instructions, output stalled.
        in_valid_i = 1'b0;
        cycle();
        out_ready_i = 1'b0;
        drive(32'h0000_0093 | (32'd11 << 20), 32'h0000_00A1, 32'd0);
        cycle();
        drive(32'h0000_0093 | (32'd22 << 20), 32'h0000_00B2, 32'd0);
        cycle();
        chk("bp_in_ready_low", 32'(in_ready_o), 32'd0);
        hold_op1 = operand1_o;
        drive(32'h0000_0093 | (32'd33 << 20), 32'h0000_00C3, 32'd0);
        cycle();
        chk("bp_hold_op1", operand1_o, 32'h0000_00A1);
        chk("bp_hold_op1b", hold_op1, 32'h0000_00A1);
        out_ready_i = 1'b1;
        cycle();
        chk("bp_drain_2nd", operand1_o, 32'h0000_00B2);
        cycle();
        chk("bp_drain_3rd", operand1_o, 32'h0000_00C3);
        in_valid_i = 1'b0;
        cycle();
        chk("bp_empty", 32'(out_valid_o), 32'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 500; i++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            instr_i     = rand_instr();
            pc_i        = $urandom;
            rs1_data_i  = $urandom;
            rs2_data_i  = $urandom;
            cycle();
        end

        // Reset mid-stall with both entries full.
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        out_ready_i = 1'b0;
        drive(32'h0010_0093, 32'h1, 32'h0);
        cycle();
        drive(32'h0020_0093, 32'h2, 32'h0);
        cycle();
        chk("full_before_rst", 32'(q.size()), 32'd2);
        in_valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_async_valid", 32'(out_valid_o), 32'd0);
        chk("rst_async_ready", 32'(in_ready_o), 32'd1);
        q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        drive(32'h0070_0113, 32'h0000_0100, 32'h0);
        cycle();
        chk("post_rst_op2", operand2_o, 32'd7);
        in_valid_i = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_alu_issue.md
# rv32i_alu_issue

Decode-and-issue stage that drives `rv32i_alu`. It accepts a 32-bit RV32I instruction plus register-file read data over a valid/ready handshake. It decodes the instruction into the ALU's one-hot 10-bit operation code and the two operands, then presents the result through a registered, 2-entry skid-buffered output. It sits between the register-read stage and the ALU/writeback, and adds exactly one cycle of latency.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `in_valid_i`  in  1  upstream has an instruction.
- `in_ready_o`  out  1  stage can accept; transfer occurs when `in_valid_i & in_ready_o`.
- `instr_i`  in  32  instruction word.
- `pc_i`  in  XLEN  address of the instruction.
- `rs1_data_i`, `rs2_data_i`  in  XLEN  register values for instr[19:15] and instr[24:20].
- `out_valid_o`  out  1  decoded entry available.
- `out_ready_i`  in  1  ALU side consumes; transfer occurs when `out_valid_o & out_ready_i`.
- `operation_o`  out  10  one-hot ALU op code: ADD=0x001, SUB=0x002, SLT=0x004, SLTU=0x008, AND=0x010, OR=0x020, XOR=0x040, SLL=0x080, SRL=0x100, SRA=0x200. A value of 0 means no operation.
- `operand1_o`, `operand2_o`  out  XLEN  ALU operands.
- `rd_o`  out  5  destination register.
- `rd_write_o`  out  1  writeback enable; forced to 0 when rd == 0.
- `branch_o`  out  1  entry is a conditional branch.
- `branch_funct3_o`  out  3  instr[14:12]; valid when `branch_o` is 1.
- `illegal_o`  out  1  unsupported opcode. This port is present only when the macro is defined.

## Operation
Decode is keyed on opcode instr[6:0].
- OP (0x33):
  - op1 = rs1, op2 = rs2, `rd_write_o` = 1.
  - funct3 mapping: 000 → ADD, or SUB if instr[30]; 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR; 101 → SRL, or SRA if instr[30]; 110 → OR; 111 → AND.
- OP-IMM (0x13):
  - Same funct3 mapping as OP, except 000 is always ADD.
  - op2 = sign-extended instr[31:20].
  - For shifts (funct3 001/101), op2 = {27'b0, instr[24:20]}; instr[30] selects SRA.
- LUI (0x37): ADD; op1 = 0; op2 = {instr[31:12], 12'b0}.
- AUIPC (0x17): ADD; op1 = `pc_i`; op2 = {instr[31:12], 12'b0}.
- BRANCH (0x63): SUB; op1 = rs1; op2 = rs2; `branch_o` = 1; `rd_write_o` = 0.
- Any other opcode: operation 0, operands 0, `rd_write_o` = 0, `branch_o` = 0.
- All decode is combinational on the input side. Only decoded fields are registered; the raw instruction is not.

## Timing
- Reset values:
  - `out_valid_o` = 0.
  - All data outputs = 0.
  - `in_ready_o` = 1.
  - Both buffer entries empty.
- Latency: an entry accepted at edge N appears on the outputs after edge N, when the output register was empty or draining.
- Throughput: one per cycle while `out_ready_i` = 1.
- Stalls:
  - While `out_valid_o & !out_ready_i`, every output holds stable.
  - One further input may be accepted into the skid entry.
- `in_ready_o` is registered and equals "skid entry empty".
  - It drops the cycle after the skid fills.
  - It rises the cycle after the output is consumed, at which point the skid entry moves to the output register.
- Simultaneous accept and consume with the skid empty: the new entry replaces the output register directly.
- Ordering: strictly FIFO; entries are never dropped or duplicated.
- Asserting `rst_i` mid-operation discards both entries immediately, with no clock edge required.

## Configuration
- `RV32I_ALU_ISSUE_ILLEGAL_EN`:
  - Defined: `illegal_o` exists and is registered with the entry. It is 1 for unsupported opcodes, for OP with instr[31:25] not in {0x00, 0x20}, and for shift-immediates with an invalid instr[31:25]. For these cases operation is forced to 0.
  - Not defined: the port is absent and the extra funct7 checks are skipped. Invalid funct7 values decode by instr[30] alone.

## Test plan
- ADDI x1,x0,5 (0x00500093), rs1 = 0 → op 0x001, op1 0, op2 5, rd 1, `rd_write_o` 1, one cycle after accept.
- SUB x3,x1,x2 (0x402081B3), rs1 = 10, rs2 = 3 → op 0x002, op1 10, op2 3.
- SRAI x5,x6,3 (0x40335293) → op 0x200, op2 3. LUI x7,0x12345 (0x123453B7) → op 0x001, op1 0, op2 0x12345000.
- Backpressure:
  - Stimulus: `out_ready_i` = 0 for 3 cycles while presenting 3 instructions back-to-back.
  - Response: exactly 2 are accepted and `in_ready_o` = 0 from the cycle after the 2nd accept.
  - Outputs stay stable; releasing `out_ready_i` drains both in order, followed by the 3rd.
- With the macro defined, instruction 0x00000000 → `illegal_o` 1, op 0, `rd_write_o` 0. ADD with funct7 0x01 → `illegal_o` 1.
- Reset mid-stall with both entries full → `out_valid_o` 0 and `in_ready_o` 1 immediately. No stale entry appears after reset releases.
